io_peripheral_responder: RTL

Responder side of the CPU IO bus. It decodes the CPU's address/read/write strobes and answers every transaction with a one-cycle ready pulse and registered read data. Behind the bus it exposes four registers: an ID word, an LED register, a free-running tick counter, and a buffered receive-byte FIFO fed by a byte stream (for example the UART receiver). It sits between the CPU IO port and the board-level peripherals in the top level, all in the clk_48 domain.

---
 rtl/io_peripheral_responder_if.sv | 23 ++
 rtl/io_peripheral_responder.sv | 93 +++++++++
 2 files changed

// File: rtl/io_peripheral_responder_if.sv
// CPU IO bus between the CPU IO port (master) and the peripheral responder (slave).
interface io_peripheral_responder_if;
    logic        io_addr_strobe;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [31:0] io_addr;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;

    modport master (
        output io_addr_strobe, io_read_strobe, io_write_strobe,
        output io_addr, io_byte_enable, io_write_data,
        input  io_read_data, io_ready
    );

    modport slave (
        input  io_addr_strobe, io_read_strobe, io_write_strobe,
        input  io_addr, io_byte_enable, io_write_data,
        output io_read_data, io_ready
    );
endinterface

// File: rtl/io_peripheral_responder.sv
// IO bus responder: ID, LED, tick counter and an RX byte FIFO, one-cycle ready per transaction.
module io_peripheral_responder #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input  logic                      clk_48,
    input  logic                      rst,
    io_peripheral_responder_if.slave  io,
    input  logic [7:0]                rx_data,
    input  logic                      rx_data_valid,
    output logic [2:0]                led
);
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
    localparam logic [31:0] ID_WORD = 32'h4F4D4931;

    typedef enum logic [1:0] {
        REG_ID     = 2'd0,
        REG_LED    = 2'd1,
        REG_TICK   = 2'd2,
        REG_RXFIFO = 2'd3
    } reg_sel_e;

    reg_sel_e                   sel;
    logic                       wr_txn, rd_txn;
    logic                       full, empty, pop_ok, push_ok;
    logic                       ovf_set, ovf_clr, overflow;
    logic [31:0]                tick, rd_word;
    logic [7:0]                 mem [DEPTH];
    logic [7:0]                 head;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]              count, count_after;
    logic                       unused;

    assign unused = ^{io.io_addr[31:4], io.io_addr[1:0], io.io_byte_enable[3:1], io.io_write_data[31:3]};

    always_comb begin
        sel     = reg_sel_e'(io.io_addr[3:2]);
        // Both or neither strobe: answered like a read, but with no side effects at all.
        wr_txn  = io.io_addr_strobe & io.io_write_strobe & ~io.io_read_strobe;
        rd_txn  = io.io_addr_strobe & io.io_read_strobe & ~io.io_write_strobe;
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        pop_ok  = rd_txn && (sel == REG_RXFIFO) && !empty;
        // Full check ignores a same-cycle pop: the freed slot is not reusable until next cycle.
        push_ok = rx_data_valid & ~full;
        ovf_set = rx_data_valid & full;
        ovf_clr = wr_txn && (sel == REG_RXFIFO) && io.io_byte_enable[0] && io.io_write_data[0];
        head    = mem[rd_ptr];
        count_after = count - CW'(pop_ok);
        rd_word = '0;
        case (sel)
            REG_ID:     rd_word = ID_WORD;
            REG_LED:    rd_word = {29'b0, led};
            REG_TICK:   rd_word = tick;
            REG_RXFIFO: rd_word = {pop_ok, overflow, 14'b0, 8'(count_after), pop_ok ? head : 8'h00};
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge clk_48 or posedge rst) begin
        if (rst) begin
            io.io_ready     <= 1'b0;
            io.io_read_data <= '0;
            led             <= '0;
            tick            <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            overflow        <= 1'b0;
        end else begin
            io.io_ready     <= io.io_addr_strobe;
            io.io_read_data <= io.io_addr_strobe ? rd_word : '0;
            if (wr_txn && (sel == REG_LED) && io.io_byte_enable[0])
                led <= io.io_write_data[2:0];
            // A write clears the count in the strobe cycle, so the following cycle already reads 1.
            tick <= (wr_txn && (sel == REG_TICK)) ? 32'd1 : tick + 32'd1;
            if (push_ok)
                wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
            if (ovf_set)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_48) begin
        if (push_ok)
            mem[wr_ptr] <= rx_data;
    end
endmodule
